// File: rtl/airi5c_ex_wb_stage.sv
// EX->WB pipeline stage: two-entry skid buffer behind the ALU with a
// registered ready, branch/jump redirect pulse, writeback word formation
// (ALU result or PC+4 link) and a forwarding tap on the head entry.
module airi5c_ex_wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   ex_alu_out_i,
  input  logic              ex_cmp_true_i,
  input  logic              ex_is_branch_i,
  input  logic              ex_is_jump_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_we_i,
  input  logic              kill_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_we_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_rd_o,
  output logic [XLEN-1:0]   fwd_data_o
);

  // state      | meaning
  // ST_EMPTY   | no entry held
  // ST_ONE     | head entry valid
  // ST_FULL    | head and skid entries valid, ready deasserted
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_ONE = XLEN'(1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [REG_AW-1:0] head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
  logic              head_we_q, head_we_d, skid_we_q, skid_we_d;
  logic [XLEN-1:0]   head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic              accept;
  logic              pop;
  logic              taken;
  logic              in_we;
  logic [XLEN-1:0]   in_data;

  assign wb_valid_o = (state_q != ST_EMPTY);
  assign accept     = ex_valid_i & ready_q;
  assign pop        = wb_valid_o & wb_ready_i;
  assign taken      = ex_is_jump_i | (ex_is_branch_i & ex_cmp_true_i);
  // Writes to x0 are dropped here so downstream never needs to check rd.
  assign in_we      = ex_we_i & (ex_rd_i != '0);
  assign in_data    = ex_is_jump_i ? (ex_pc_i + PC_INC) : ex_alu_out_i;

  // Next-state, buffer steering, redirect and registered-ready computation.
  always_comb begin
    state_d       = state_q;
    head_rd_d     = head_rd_q;
    head_we_d     = head_we_q;
    head_data_d   = head_data_q;
    skid_rd_d     = skid_rd_q;
    skid_we_d     = skid_we_q;
    skid_data_d   = skid_data_q;
    redirect_d    = accept & taken;
    redirect_pc_d = (accept & taken) ? (ex_target_i & ~LSB_ONE) : redirect_pc_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          head_rd_d   = ex_rd_i;
          head_we_d   = in_we;
          head_data_d = in_data;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_d     = ST_FULL;
          skid_rd_d   = ex_rd_i;
          skid_we_d   = in_we;
          skid_data_d = in_data;
        end else if (accept && pop) begin
          head_rd_d   = ex_rd_i;
          head_we_d   = in_we;
          head_data_d = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d     = ST_ONE;
          head_rd_d   = skid_rd_q;
          head_we_d   = skid_we_q;
          head_data_d = skid_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A flush discards held entries and anything accepted on the same edge.
    if (kill_i) begin
      state_d       = ST_EMPTY;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
    end

    ready_d = (state_d != ST_FULL);
  end

  // State, buffer and redirect registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_EMPTY;
      ready_q       <= 1'b0;
      head_rd_q     <= '0;
      head_we_q     <= 1'b0;
      head_data_q   <= '0;
      skid_rd_q     <= '0;
      skid_we_q     <= 1'b0;
      skid_data_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      head_rd_q     <= head_rd_d;
      head_we_q     <= head_we_d;
      head_data_q   <= head_data_d;
      skid_rd_q     <= skid_rd_d;
      skid_we_q     <= skid_we_d;
      skid_data_q   <= skid_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign ex_ready_o    = ready_q;
  assign wb_rd_o       = head_rd_q;
  assign wb_we_o       = head_we_q;
  assign wb_data_o     = head_data_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign fwd_valid_o   = wb_valid_o & head_we_q;
  assign fwd_rd_o      = head_rd_q;
  assign fwd_data_o    = head_data_q;

endmodule
